pipe_issue_ctrl: RTL and testbench

Single-clock issue controller that feeds the 4-stage register/ALU/memory pipeline (16×16 register bank, 4-bit func, 8-bit memory address). It buffers incoming instructions in a small FIFO, detects read-after-write hazards against recently issued instructions, and inserts harmless bubble instructions until the hazard clears. It removes the need for the stimulus source to hand-space dependent instructions.

---
 rtl/pipe_issue_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: issue controller for the 4-stage register/ALU/memory pipeline.
// Buffers incoming instructions in a small FIFO and issues exactly one slot per
// clock. The slot is the FIFO head when it is free of read-after-write hazards
// against the last HAZ_DEPTH issued slots; otherwise it is a harmless bubble
// (R[BUBBLE_RD] := R[BUBBLE_RD], written to SCRATCH_ADDR).
// Optional feature: define PIPE_PERF_CNT_EN to add the saturating issue_cnt and
// stall_cnt performance counters and their ports.
module pipe_issue_ctrl #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          HAZ_DEPTH    = 2,
    parameter logic [3:0]  BUBBLE_RD    = 4'd0,
    parameter logic [7:0]  SCRATCH_ADDR = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        out_bubble,
    output logic        stall,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        idle
);

    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam int              CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]      BUBBLE_FUNC = 4'd3;  // pass A

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    localparam instr_t BUBBLE = '{rs1: BUBBLE_RD, rs2: BUBBLE_RD, rd: BUBBLE_RD,
                                  func: BUBBLE_FUNC, addr: SCRATCH_ADDR};

    // Operand A is read by every func except 4, 9 and 12..15.
    function automatic logic uses_a(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Operand B is read only by funcs 0..2, 4..7 and 9.
    function automatic logic uses_b(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    instr_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               win_real_q [HAZ_DEPTH];
    logic [3:0]         win_rd_q   [HAZ_DEPTH];

    instr_t             out_q;
    logic               out_bubble_q;

    instr_t             head;
    logic               head_valid;
    logic               hazard;
    logic               win_has_real;
    logic               push;
    logic               pop;

    assign head       = fifo_mem[rd_ptr_q];
    assign head_valid = (count_q != '0);
    // Full blocks a push even when the head pops on the same edge.
    assign in_ready   = rst_n && (count_q != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = head_valid && !hazard;
    assign stall      = head_valid && hazard;
    assign idle       = !head_valid && !win_has_real;

    // Compare the head's used source registers against every real window entry.
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        hazard       = 1'b0;
        win_has_real = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (win_real_q[i]) begin
                win_has_real = 1'b1;
                if (uses_a(head.func) && (win_rd_q[i] == head.rs1)) hazard = 1'b1;
                if (uses_b(head.func) && (win_rd_q[i] == head.rs2)) hazard = 1'b1;
            end
        end
    end

    // Next-state for FIFO pointers and occupancy; pointers wrap modulo FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // FIFO pointer/occupancy registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write.
    // NOTE: the storage array is deliberately not reset; count_q guards every read, so stale entries are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                                    func: in_func, addr: in_addr};
        end
    end

    // Issue register: the hazard-free head, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= BUBBLE;
            out_bubble_q <= 1'b1;
        end else if (pop) begin
            out_q        <= head;
            out_bubble_q <= 1'b0;
        end else begin
            out_q        <= BUBBLE;
            out_bubble_q <= 1'b1;
        end
    end

    // Hazard window: entry 0 is the slot issued at the previous edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                win_real_q[i] <= 1'b0;
                win_rd_q[i]   <= BUBBLE_RD;
            end
        end else begin
            win_real_q[0] <= pop;
            win_rd_q[0]   <= pop ? head.rd : BUBBLE_RD;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                win_real_q[i] <= win_real_q[i-1];
                win_rd_q[i]   <= win_rd_q[i-1];
            end
        end
    end

    assign rs1        = out_q.rs1;
    assign rs2        = out_q.rs2;
    assign rd         = out_q.rd;
    assign func       = out_q.func;
    assign addr       = out_q.addr;
    assign out_bubble = out_bubble_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating counters of real issues and stalled edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (issue_cnt_q != 16'hFFFF))   issue_cnt_q <= issue_cnt_q + 16'd1;
            if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run, all compared against a queue-based
// reference model of the issue rules.
module tb_pipe_issue_ctrl;

    localparam int         DEPTH  = 4;
    localparam int         HDEPTH = 2;
    localparam logic [3:0] BRD    = 4'd0;
    localparam logic [7:0] BADDR  = 8'd255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
    logic [7:0]  in_addr;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        out_bubble, stall, idle;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] issue_cnt, stall_cnt;
`endif

    pipe_issue_ctrl #(
        .FIFO_DEPTH(DEPTH), .HAZ_DEPTH(HDEPTH), .BUBBLE_RD(BRD), .SCRATCH_ADDR(BADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .out_bubble(out_bubble), .stall(stall),
`ifdef PIPE_PERF_CNT_EN
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef struct packed {
        logic       is_real;
        logic [3:0] rd;
    } slot_t;

    instr_t      m_q[$];
    slot_t       m_win[$];
    instr_t      m_out;
    logic        m_bub;
    int          m_issue_cnt, m_stall_cnt;
    logic [15:0] uses_a_mask = 16'h0DEF;  // funcs 0-3,5-8,10,11
    logic [15:0] uses_b_mask = 16'h02F7;  // funcs 0-2,4-7,9

    function automatic instr_t bubble_instr();
        return '{rs1: BRD, rs2: BRD, rd: BRD, func: 4'd3, addr: BADDR};
    endfunction

    function automatic logic m_hazard();
        if (m_q.size() == 0) return 1'b0;
        foreach (m_win[i]) begin
            if (m_win[i].is_real) begin
                if (uses_a_mask[m_q[0].func] && m_win[i].rd == m_q[0].rs1) return 1'b1;
                if (uses_b_mask[m_q[0].func] && m_win[i].rd == m_q[0].rs2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic m_idle();
        if (m_q.size() != 0) return 1'b0;
        foreach (m_win[i]) if (m_win[i].is_real) return 1'b0;
        return 1'b1;
    endfunction

    // Apply one clock edge's worth of rules using the current (pre-edge) inputs.
    task automatic model_step();
        logic   st, do_push;
        instr_t incoming;
        if (!rst_n) begin
            m_q.delete();
            m_win.delete();
            for (int i = 0; i < HDEPTH; i++) m_win.push_back('{is_real: 1'b0, rd: BRD});
            m_out = bubble_instr();
            m_bub = 1'b1;
            m_issue_cnt = 0;
            m_stall_cnt = 0;
            return;
        end
        st       = m_hazard();
        do_push  = in_valid && (m_q.size() < DEPTH);
        incoming = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
        if (st && m_stall_cnt < 65535) m_stall_cnt++;
        if (m_q.size() > 0 && !st) begin
            m_out = m_q.pop_front();
            m_bub = 1'b0;
            m_win.push_front('{is_real: 1'b1, rd: m_out.rd});
            if (m_issue_cnt < 65535) m_issue_cnt++;
        end else begin
            m_out = bubble_instr();
            m_bub = 1'b1;
            m_win.push_front('{is_real: 1'b0, rd: BRD});
        end
        void'(m_win.pop_back());
        if (do_push) m_q.push_back(incoming);
    endtask

    task automatic compare_model();
        check("out_slot", {m_bub, rs1, rs2, rd, func, addr}, {m_bub, m_out});
        check("out_bubble", out_bubble, m_bub);
        check("in_ready", in_ready, rst_n && (m_q.size() < DEPTH));
        check("stall", stall, m_hazard());
        check("idle", idle, m_idle());
`ifdef PIPE_PERF_CNT_EN
        check("issue_cnt", issue_cnt, m_issue_cnt);
        check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
    endtask

    // One clock: model advances with the driven inputs, DUT sampled 1ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [3:0] f, input logic [7:0] ad);
        in_valid = v; in_rs1 = a; in_rs2 = b; in_rd = d; in_func = f; in_addr = ad;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       valid;
        logic [3:0] rs1, rs2, rd, func;
        logic [7:0] addr;
        logic       exp_bub;
        logic [3:0] exp_rd, exp_func;
        logic       exp_stall, exp_idle, exp_ready;
    } vec_t;

    function automatic vec_t mk(input int v, input int a, input int b, input int d,
                                input int f, input int ad, input int eb, input int erd,
                                input int ef, input int es, input int ei, input int er);
        vec_t m;
        m.valid = v[0];  m.rs1 = a[3:0]; m.rs2 = b[3:0]; m.rd = d[3:0];
        m.func = f[3:0]; m.addr = ad[7:0];
        m.exp_bub = eb[0]; m.exp_rd = erd[3:0]; m.exp_func = ef[3:0];
        m.exp_stall = es[0]; m.exp_idle = ei[0]; m.exp_ready = er[0];
        return m;
    endfunction

    vec_t   vecs[16];
    logic   saw_full;
    int     cyc, k, real_seen;
    logic [3:0] got_rd[$];

    initial begin
        //                v  rs1 rs2 rd f  addr  bub rd f  st idl rdy
        vecs[0]  = mk(1, 10, 5, 10, 5, 125,   1,  0, 3, 0, 0, 1);
        vecs[1]  = mk(0,  0, 0,  0, 0,   0,   0, 10, 5, 0, 0, 1);
        vecs[2]  = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 0, 0, 1);
        vecs[3]  = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 0, 1, 1);
        vecs[4]  = mk(1, 12, 8, 12, 5, 126,   1,  0, 3, 0, 0, 1);
        vecs[5]  = mk(1, 13, 5, 14, 0, 128,   0, 12, 5, 0, 0, 1);
        vecs[6]  = mk(1,  1, 2, 13, 5,   0,   0, 14, 0, 0, 0, 1);
        vecs[7]  = mk(1,  7,13,  3,11,   7,   0, 13, 5, 0, 0, 1);
        vecs[8]  = mk(0,  0, 0,  0, 0,   0,   0,  3,11, 0, 0, 1);
        vecs[9]  = mk(1,  0, 0, 13, 5,   9,   1,  0, 3, 0, 0, 1);
        vecs[10] = mk(1,  7,13,  4, 0,   8,   0, 13, 5, 1, 0, 1);
        vecs[11] = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 1, 0, 1);
        vecs[12] = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 0, 0, 1);
        vecs[13] = mk(0,  0, 0,  0, 0,   0,   0,  4, 0, 0, 0, 1);
        vecs[14] = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 0, 0, 1);
        vecs[15] = mk(0,  0, 0,  0, 0,   0,   1,  0, 3, 0, 1, 1);

        // ---- reset state ----
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_out", {out_bubble, rs1, rs2, rd, func, addr}, {1'b1, BRD, BRD, BRD, 4'd3, BADDR});
        check("rst_flags", {stall, idle, in_ready}, 3'b010);
`ifdef PIPE_PERF_CNT_EN
        check("rst_cnts", {issue_cnt, stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1'b1);

        // ---- directed table: latency, independent pair, operand-use, two-bubble stall ----
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].func, vecs[i].addr);
            tick();
            check($sformatf("vec%0d", i), {out_bubble, rd, func, stall, idle, in_ready},
                  {vecs[i].exp_bub, vecs[i].exp_rd, vecs[i].exp_func,
                   vecs[i].exp_stall, vecs[i].exp_idle, vecs[i].exp_ready});
        end
        drive(0, 0, 0, 0, 0, 0);

        // ---- chain of 6 dependent instructions pushed back-to-back ----
        k = 0; cyc = 0; saw_full = 1'b0;
        got_rd.delete();
        while (k < 6 && cyc < 100) begin
            logic acc;
            drive(1, (k == 0) ? 4'd15 : 4'(k), 4'd15, 4'(k + 1), 4'd5, 8'(k));
            acc = in_ready;
            tick();
            cyc++;
            if (acc) k++;
            if (!in_ready) saw_full = 1'b1;
            if (!out_bubble) got_rd.push_back(rd);
        end
        drive(0, 0, 0, 0, 0, 0);
        while (got_rd.size() < 6 && cyc < 100) begin
            tick();
            cyc++;
            if (!out_bubble) got_rd.push_back(rd);
        end
        check("chain_count", got_rd.size(), 6);
        check("chain_full_seen", saw_full, 1'b1);
        for (int i = 0; i < 6 && i < got_rd.size(); i++)
            check($sformatf("chain_order%0d", i), got_rd[i], 4'(i + 1));
        for (int i = 0; i < 4; i++) tick();
        check("chain_idle", idle, 1'b1);

        // ---- reset while stalled with 3 queued ----
        drive(1, 4'd15, 4'd15, 4'd9, 4'd5, 8'd1);  tick();   // W  rd9
        drive(1, 4'd9,  4'd15, 4'd9, 4'd5, 8'd2);  tick();   // X  needs W
        drive(1, 4'd9,  4'd15, 4'd10, 4'd5, 8'd3); tick();   // Y  needs X
        drive(1, 4'd9,  4'd15, 4'd11, 4'd5, 8'd4); tick();   // Z
        drive(1, 4'd9,  4'd15, 4'd12, 4'd5, 8'd5); tick();   // Q
        check("pre_rst_stall", stall, 1'b1);
        check("pre_rst_queued", m_q.size(), 3);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("ready_in_rst", in_ready, 1'b0);
        tick();
        check("rst_mid_out", {out_bubble, stall, idle}, 3'b101);
        rst_n = 1'b1;
        real_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_bubble) real_seen++;
        end
        check("discarded_never_issue", real_seen, 0);

        // ---- two-bubble stall again, from freshly reset counters ----
        drive(1, 4'd0, 4'd0, 4'd13, 4'd5, 8'd9);  tick();
        drive(1, 4'd7, 4'd13, 4'd4, 4'd0, 8'd8);  tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_PERF_CNT_EN
        check("perf_issue", issue_cnt, 16'd2);
        check("perf_stall", stall_cnt, 16'd2);
`endif
        check("perf_seq_idle", idle, 1'b1);

        // ---- randomized run against the model ----
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            drive(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick();
        check("final_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
